// File: rtl/usbfs_in_arbiter_pkg.sv
// Shared types and constants for the USB FS IN-endpoint arbiter and the
// round-robin picker it uses.
//   state_t   : arbiter FSM states (HDR is only reachable in tagged builds)
//   HDR_MAGIC : upper nibble of the per-grant tag byte
//   clog2     : width helper that never returns less than 1
package usbfs_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    // Clamped to 1 so a degenerate parameter never produces a zero-width bus.
    function automatic int clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/usbfs_in_arbiter_if.sv
// Byte-stream bundle between NCH requester channels, the arbiter and the
// controller IN port (endpoint 0x81).
//   req_data  : NCH bytes, channel k on [8k+7:8k]
//   req_valid : per-channel byte valid
//   req_ready : per-channel ready back to the requesters
//   in_data   : byte to the controller
//   in_valid  : byte valid to the controller
//   in_ready  : controller ready
// Modports: master = arbiter side, slave = requesters + controller side.
interface usbfs_in_arbiter_if #(
    parameter int NCH = 4
);
    logic [NCH*8-1:0] req_data;
    logic [NCH-1:0]   req_valid;
    logic [NCH-1:0]   req_ready;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        input  req_data, req_valid, in_ready,
        output req_ready, in_data, in_valid
    );

    modport slave (
        output req_data, req_valid, in_ready,
        input  req_ready, in_data, in_valid
    );
endinterface

// File: rtl/usbfs_in_arbiter_rr_pick.sv
// Combinational round-robin picker. Searches req upward starting at last+1,
// wrapping at NCH, and returns the first set position.
//   req   : request vector
//   last  : most recently served index
//   found : at least one request is set
//   idx   : selected index (0 when found is low)
module usbfs_rr_pick
    import usbfs_arb_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int IDW = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] last,
    output logic           found,
    output logic [IDW-1:0] idx
);

    always_comb begin
        int             cand;
        logic [NCH-1:0] rot;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        rot   = '0;
        // i runs 1..NCH so the last-served channel is considered last.
        for (int i = 1; i <= NCH; i++) begin
            cand = (int'(last) + i) % NCH;
            rot  = req >> cand;
            if (!found && rot[0]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/usbfs_in_arbiter.sv
// Shares the single device-to-host endpoint 0x81 byte stream among NCH
// requester channels. One channel is granted at a time in round-robin order;
// a grant lasts up to BURST bytes or until the granted channel drops valid.
//   clk      : 60 MHz system clock
//   rstn     : asynchronous active-low reset
//   bus      : usbfs_in_arbiter_if.master (requester and controller streams)
//   grant_id : currently or last granted channel
//   busy     : high while a grant is active
// Build option: define USBFS_IN_ARB_HDR_EN to prefix every grant with a tag
// byte {HDR_MAGIC, grant_id} so the host can demultiplex the stream.
module usbfs_in_arbiter
    import usbfs_arb_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int BURST = 32,
    localparam int IDW   = clog2(NCH),
    localparam int CW    = clog2(BURST + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    usbfs_in_arbiter_if.master  bus,
    output logic [IDW-1:0]      grant_id,
    output logic                busy
);

    state_t         state;
    logic [IDW-1:0] last;
    logic [CW-1:0]  cnt;
    logic           found;
    logic [IDW-1:0] pick_idx;
    logic           gnt_valid;

    usbfs_rr_pick #(.NCH(NCH)) u_pick (
        .req   (bus.req_valid),
        .last  (last),
        .found (found),
        .idx   (pick_idx)
    );

    assign gnt_valid = bus.req_valid[grant_id];

    // Data path is a pure mux off the registered grant, so a requester sees
    // the controller's ready in the same cycle.
    always_comb begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.req_ready = '0;
        case (state)
            DATA: begin
                bus.in_valid            = gnt_valid;
                bus.in_data             = bus.req_data[{grant_id, 3'b000} +: 8];
                bus.req_ready[grant_id] = bus.in_ready;
            end
`ifdef USBFS_IN_ARB_HDR_EN
            HDR: begin
                bus.in_valid = 1'b1;
                bus.in_data  = {HDR_MAGIC, 4'(grant_id)};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            grant_id <= '0;
            last     <= IDW'(NCH - 1);
            cnt      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick_idx;
                        cnt      <= '0;
                        busy     <= 1'b1;
`ifdef USBFS_IN_ARB_HDR_EN
                        state    <= HDR;
`else
                        state    <= DATA;
`endif
                    end
                end
`ifdef USBFS_IN_ARB_HDR_EN
                HDR: begin
                    // Tag is held until accepted; it does not consume BURST.
                    if (bus.in_ready) begin
                        state <= DATA;
                    end
                end
`endif
                DATA: begin
                    if (!gnt_valid) begin
                        last  <= grant_id;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (bus.in_ready) begin
                        if (cnt == CW'(BURST - 1)) begin
                            last  <= grant_id;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
